// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: one-hot instruction class bit
// indices (common with the memory stage), MDU opcodes and default timing.
// The optional divider is controlled by the DIV_EN macro in the users of
// this package.
package ex_stage_pkg;

  localparam int INSTR_W = 60;

  // One-hot InstrType bit indices
  localparam int IT_ADDU  = 0;
  localparam int IT_SUBU  = 1;
  localparam int IT_ORI   = 2;
  localparam int IT_LUI   = 3;
  localparam int IT_SLL   = 4;
  localparam int IT_LW    = 5;
  localparam int IT_SW    = 6;
  localparam int IT_JAL   = 7;
  localparam int IT_MULT  = 8;
  localparam int IT_MULTU = 9;
  localparam int IT_DIV   = 10;
  localparam int IT_DIVU  = 11;
  localparam int IT_MFHI  = 12;
  localparam int IT_MFLO  = 13;
  localparam int IT_MTHI  = 14;
  localparam int IT_MTLO  = 15;

  // Default MDU latencies and reset PC
  localparam int          MULT_CYCLES_DEF = 5;
  localparam int          DIV_CYCLES_DEF  = 10;
  localparam logic [31:0] RESET_PC_DEF    = 32'h0000_3000;

  // Width of the MDU cycle counter; large enough for any sane latency
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

endpackage

// File: rtl/ex_stage_mdu.sv
// Multi-cycle multiply/divide unit holding HI/LO.
// Operands and opcode are captured at start; the result is written to HI/LO
// when the counter steps from 1 to 0. Divide support only exists when the
// DIV_EN macro is defined; divide by zero leaves HI/LO untouched.
module ex_stage_mdu
  import ex_stage_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [CNT_W-1:0] cnt_reg;
  md_op_e           op_reg;
  logic [31:0]      a_reg;
  logic [31:0]      b_reg;
  logic [31:0]      hi_reg;
  logic [31:0]      lo_reg;

  logic signed [63:0] a_sext;
  logic signed [63:0] b_sext;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;
  logic               res_we;
  logic               finishing;

  assign busy      = (cnt_reg != '0);
  assign finishing = (cnt_reg == CNT_W'(1));
  assign hi        = hi_reg;
  assign lo        = lo_reg;

  assign a_sext = {{32{a_reg[31]}}, a_reg};
  assign b_sext = {{32{b_reg[31]}}, b_reg};
  assign prod_s = a_sext * b_sext;
  assign prod_u = {32'd0, a_reg} * {32'd0, b_reg};

`ifdef DIV_EN
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] quo_u;
  logic [31:0] rem_u;

  // Signed / and % in SV truncate toward zero, remainder follows dividend
  assign quo_s = 32'($signed(a_reg) / $signed(b_reg));
  assign rem_s = 32'($signed(a_reg) % $signed(b_reg));
  assign quo_u = a_reg / b_reg;
  assign rem_u = a_reg % b_reg;
`endif

  // Select the result to be committed from the latched opcode
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    res_we = 1'b0;
    case (op_reg)
      MD_MULT: begin
        {res_hi, res_lo} = prod_s;
        res_we           = 1'b1;
      end
      MD_MULTU: begin
        {res_hi, res_lo} = prod_u;
        res_we           = 1'b1;
      end
`ifdef DIV_EN
      MD_DIV: begin
        if (b_reg != 32'd0) begin
          res_lo = quo_s;
          res_hi = rem_s;
          res_we = 1'b1;
        end
      end
      MD_DIVU: begin
        if (b_reg != 32'd0) begin
          res_lo = quo_u;
          res_hi = rem_u;
          res_we = 1'b1;
        end
      end
`endif
      default: begin
        res_we = 1'b0;
      end
    endcase
  end

  // Counter, operand capture and HI/LO updates; reset discards any operation
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
      op_reg  <= MD_MULT;
      a_reg   <= '0;
      b_reg   <= '0;
      hi_reg  <= '0;
      lo_reg  <= '0;
    end else begin
      if (start && !busy) begin
        op_reg  <= op;
        a_reg   <= a;
        b_reg   <= b;
        cnt_reg <= ((op == MD_DIV) || (op == MD_DIVU)) ? CNT_W'(DIV_CYCLES)
                                                       : CNT_W'(MULT_CYCLES);
      end else if (busy) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
        if (finishing && res_we) begin
          hi_reg <= res_hi;
          lo_reg <= res_lo;
        end
      end
      // mthi/mtlo are only granted while idle, so they never race a commit
      if (hi_we) begin
        hi_reg <= wdata;
      end
      if (lo_we) begin
        lo_reg <= wdata;
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline: ALU, multiply/divide unit
// and the EX/Mem pipeline register. Defining DIV_EN enables div/divu;
// otherwise they pass down the pipe with no MDU effect.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int          MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int          DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         Rs_ID_to_EX,
  input  logic [4:0]         Rt_ID_to_EX,
  input  logic [4:0]         RegWriteAddr_ID_to_EX,
  input  logic [INSTR_W-1:0] InstrType_ID_to_EX,
  input  logic [31:0]        RsData_ID_to_EX,
  input  logic [31:0]        RtData_ID_to_EX,
  input  logic [31:0]        Imm_ID_to_EX,
  input  logic [4:0]         Shamt_ID_to_EX,
  input  logic [31:0]        PC_ID_to_EX,
  output logic [4:0]         Rs_EX_to_Mem,
  output logic [4:0]         Rt_EX_to_Mem,
  output logic [4:0]         RegWriteAddr_EX_to_Mem,
  output logic [INSTR_W-1:0] InstrType_EX_to_Mem,
  output logic [31:0]        ALUOut_EX_to_Mem,
  output logic [31:0]        DMWriteData_EX_to_Mem,
  output logic [31:0]        PC_EX_to_Mem,
  output logic               MDBusy,
  output logic               Stall_EX
);

  logic [INSTR_W-1:0] it;
  logic               is_mult;
  logic               is_div;
  logic               md_class;
  logic               md_start;
  logic               hi_we;
  logic               lo_we;
  md_op_e             md_op;
  logic               md_busy;
  logic [31:0]        hi;
  logic [31:0]        lo;
  logic [31:0]        alu_out;

  assign it      = InstrType_ID_to_EX;
  assign is_mult = it[IT_MULT] | it[IT_MULTU];
`ifdef DIV_EN
  assign is_div  = it[IT_DIV] | it[IT_DIVU];
`else
  assign is_div  = 1'b0;
`endif
  assign md_class = is_mult | is_div | it[IT_MFHI] | it[IT_MFLO] |
                    it[IT_MTHI] | it[IT_MTLO];

  // An MD instruction only has to wait while a previous operation occupies
  // the unit. The instruction that starts the unit is itself the start, and
  // busy rises right after that edge, so it covers every later MD request.
  assign Stall_EX = md_busy & md_class & ~reset;
  assign MDBusy   = md_busy;

  assign md_start = (is_mult | is_div) & ~md_busy;
  assign hi_we    = it[IT_MTHI] & ~md_busy;
  assign lo_we    = it[IT_MTLO] & ~md_busy;

  // Opcode encoding for the MDU from the one-hot class
  always_comb begin
    md_op = MD_MULT;
    if (it[IT_MULTU]) begin
      md_op = MD_MULTU;
    end else if (it[IT_DIV]) begin
      md_op = MD_DIV;
    end else if (it[IT_DIVU]) begin
      md_op = MD_DIVU;
    end
  end

  ex_stage_mdu #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_mdu (
    .clk  (clk),
    .reset(reset),
    .start(md_start),
    .op   (md_op),
    .a    (RsData_ID_to_EX),
    .b    (RtData_ID_to_EX),
    .hi_we(hi_we),
    .lo_we(lo_we),
    .wdata(RsData_ID_to_EX),
    .busy (md_busy),
    .hi   (hi),
    .lo   (lo)
  );

  // ALU: classes are one-hot, so at most one term fires; others give 0
  always_comb begin
    alu_out = '0;
    if (it[IT_ADDU]) alu_out = RsData_ID_to_EX + RtData_ID_to_EX;
    if (it[IT_SUBU]) alu_out = RsData_ID_to_EX - RtData_ID_to_EX;
    if (it[IT_ORI])  alu_out = RsData_ID_to_EX | Imm_ID_to_EX;
    if (it[IT_LUI])  alu_out = {Imm_ID_to_EX[15:0], 16'h0000};
    if (it[IT_SLL])  alu_out = RtData_ID_to_EX << Shamt_ID_to_EX;
    if (it[IT_LW] | it[IT_SW]) alu_out = RsData_ID_to_EX + Imm_ID_to_EX;
    if (it[IT_JAL])  alu_out = PC_ID_to_EX + 32'd8;
    if (it[IT_MFHI]) alu_out = hi;
    if (it[IT_MFLO]) alu_out = lo;
  end

  // EX/Mem pipeline register; a stall inserts a bubble and holds the PC
  always_ff @(posedge clk) begin
    if (reset) begin
      Rs_EX_to_Mem           <= '0;
      Rt_EX_to_Mem           <= '0;
      RegWriteAddr_EX_to_Mem <= '0;
      InstrType_EX_to_Mem    <= '0;
      ALUOut_EX_to_Mem       <= '0;
      DMWriteData_EX_to_Mem  <= '0;
      PC_EX_to_Mem           <= RESET_PC;
    end else if (Stall_EX) begin
      Rs_EX_to_Mem           <= '0;
      Rt_EX_to_Mem           <= '0;
      RegWriteAddr_EX_to_Mem <= '0;
      InstrType_EX_to_Mem    <= '0;
      ALUOut_EX_to_Mem       <= '0;
      DMWriteData_EX_to_Mem  <= '0;
    end else begin
      Rs_EX_to_Mem           <= Rs_ID_to_EX;
      Rt_EX_to_Mem           <= Rt_ID_to_EX;
      RegWriteAddr_EX_to_Mem <= RegWriteAddr_ID_to_EX;
      InstrType_EX_to_Mem    <= InstrType_ID_to_EX;
      ALUOut_EX_to_Mem       <= alu_out;
      DMWriteData_EX_to_Mem  <= RtData_ID_to_EX;
      PC_EX_to_Mem           <= PC_ID_to_EX;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage. Expected EX/Mem contents are queued when
// an instruction is driven and compared one edge later. Covers the DIV_EN
// build and the default build with matching scenario sets.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic [4:0]         rs_f, rt_f, rd_f, shamt;
  logic [INSTR_W-1:0] itype;
  logic [31:0]        rs_d, rt_d, imm, pc;
  logic [4:0]         rs_o, rt_o, rd_o;
  logic [INSTR_W-1:0] itype_o;
  logic [31:0]        alu_o, dm_o, pc_o;
  logic               md_busy, stall;

  typedef struct {
    logic [INSTR_W-1:0] it;
    logic [4:0]         rd;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [31:0]        alu;
    logic [31:0]        dm;
    logic [31:0]        pc;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk                   (clk),
    .reset                 (reset),
    .Rs_ID_to_EX           (rs_f),
    .Rt_ID_to_EX           (rt_f),
    .RegWriteAddr_ID_to_EX (rd_f),
    .InstrType_ID_to_EX    (itype),
    .RsData_ID_to_EX       (rs_d),
    .RtData_ID_to_EX       (rt_d),
    .Imm_ID_to_EX          (imm),
    .Shamt_ID_to_EX        (shamt),
    .PC_ID_to_EX           (pc),
    .Rs_EX_to_Mem          (rs_o),
    .Rt_EX_to_Mem          (rt_o),
    .RegWriteAddr_EX_to_Mem(rd_o),
    .InstrType_EX_to_Mem   (itype_o),
    .ALUOut_EX_to_Mem      (alu_o),
    .DMWriteData_EX_to_Mem (dm_o),
    .PC_EX_to_Mem          (pc_o),
    .MDBusy                (md_busy),
    .Stall_EX              (stall)
  );

  task automatic idle_inputs();
    rs_f = '0; rt_f = '0; rd_f = '0; shamt = '0; itype = '0;
    rs_d = '0; rt_d = '0; imm = '0; pc = '0;
  endtask

  // Drive one instruction for one cycle (cls < 0 means no class bit),
  // check Stall_EX, queue the expected EX/Mem contents, compare after edge.
  task automatic issue(input int cls, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [4:0] sh,
                       input logic [31:0] ipc, input logic [4:0] rd,
                       input logic exp_stall, input logic [31:0] exp_alu);
    exp_t e;
    exp_t g;
    logic [INSTR_W-1:0] t;
    t = '0;
    if (cls >= 0) t[cls] = 1'b1;
    itype = t; rs_d = a; rt_d = b; imm = im; shamt = sh; pc = ipc; rd_f = rd;
    rs_f = 5'd3; rt_f = 5'd4;
    #1;
    checks++;
    if (stall !== exp_stall) begin
      errors++;
      $display("FAIL stall cls=%0d got %b expected %b", cls, stall, exp_stall);
    end
    e.it  = exp_stall ? '0 : t;
    e.rd  = exp_stall ? 5'd0 : rd;
    e.rs  = exp_stall ? 5'd0 : 5'd3;
    e.rt  = exp_stall ? 5'd0 : 5'd4;
    e.alu = exp_stall ? 32'd0 : exp_alu;
    e.dm  = exp_stall ? 32'd0 : b;
    e.pc  = exp_stall ? exp_pc : ipc;
    exp_pc = e.pc;
    sb.push_back(e);
    @(posedge clk); #1;
    g = sb.pop_front();
    checks++;
    if (alu_o !== g.alu) begin
      errors++;
      $display("FAIL aluout cls=%0d got %h expected %h", cls, alu_o, g.alu);
    end
    checks++;
    if (itype_o !== g.it) begin
      errors++;
      $display("FAIL instrtype cls=%0d got %h expected %h", cls, itype_o, g.it);
    end
    checks++;
    if (pc_o !== g.pc) begin
      errors++;
      $display("FAIL pc cls=%0d got %h expected %h", cls, pc_o, g.pc);
    end
    checks++;
    if (rd_o !== g.rd || rs_o !== g.rs || rt_o !== g.rt || dm_o !== g.dm) begin
      errors++;
      $display("FAIL fields cls=%0d got rd=%0d rs=%0d rt=%0d dm=%h expected rd=%0d rs=%0d rt=%0d dm=%h",
               cls, rd_o, rs_o, rt_o, dm_o, g.rd, g.rs, g.rt, g.dm);
    end
    $display("txn cls=%0d stall=%b alu=%h pc=%h busy=%b", cls, exp_stall, alu_o, pc_o, md_busy);
  endtask

  task automatic check_busy(input string name, input logic want);
    checks++;
    if (md_busy !== want) begin
      errors++;
      $display("FAIL %s mdbusy got %b expected %b", name, md_busy, want);
    end
  endtask

  task automatic check_reset_state(input string name);
    checks++;
    if (pc_o !== 32'h0000_3000 || alu_o !== 32'd0 || itype_o !== '0 ||
        rd_o !== 5'd0 || rs_o !== 5'd0 || rt_o !== 5'd0 || dm_o !== 32'd0) begin
      errors++;
      $display("FAIL %s outputs got pc=%h alu=%h it=%h rd=%0d dm=%h expected pc=00003000 rest 0",
               name, pc_o, alu_o, itype_o, rd_o, dm_o);
    end
    check_busy(name, 1'b0);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL %s stall got %b expected 0", name, stall);
    end
    $display("txn reset pc=%h busy=%b", pc_o, md_busy);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_pc = 32'h0000_3000;
    check_reset_state("reset");
  endtask

  task automatic test_alu();
    issue(IT_ADDU, 32'hFFFF_FFFF, 32'd1, 0, 0, 32'h3000, 5'd8, 0, 32'h0);
    issue(IT_LUI, 0, 0, 32'h0000_1234, 0, 32'h3004, 5'd9, 0, 32'h1234_0000);
    issue(IT_JAL, 0, 0, 0, 0, 32'h3004, 5'd31, 0, 32'h0000_300C);
    issue(IT_SUBU, 32'd5, 32'd7, 0, 0, 32'h3008, 5'd10, 0, 32'hFFFF_FFFE);
    issue(IT_ORI, 32'h0000_F0F0, 0, 32'h0000_0F0F, 0, 32'h300C, 5'd11, 0, 32'h0000_FFFF);
    issue(IT_SLL, 0, 32'd1, 0, 5'd31, 32'h3010, 5'd12, 0, 32'h8000_0000);
    issue(IT_SW, 32'h1000, 32'hCAFE_BABE, 32'hFFFF_FFFC, 0, 32'h3014, 5'd0, 0, 32'h0000_0FFC);
    issue(IT_LW, 32'h2000, 0, 32'h10, 0, 32'h3018, 5'd13, 0, 32'h0000_2010);
    issue(40, 32'h1234, 32'h5678, 32'h9, 0, 32'h301C, 5'd14, 0, 32'h0);
  endtask

  task automatic test_mult();
    issue(IT_MULT, 32'hFFFF_FFFD, 32'd7, 0, 0, 32'h3020, 5'd0, 0, 32'h0);
    check_busy("mult_start", 1'b1);
    for (int k = 0; k < 5; k++)
      issue(IT_MFLO, 0, 0, 0, 0, 32'h3024, 5'd9, 1, 32'h0);
    check_busy("mult_done", 1'b0);
    issue(IT_MFLO, 0, 0, 0, 0, 32'h3024, 5'd9, 0, 32'hFFFF_FFEB);
    issue(IT_MFHI, 0, 0, 0, 0, 32'h3028, 5'd10, 0, 32'hFFFF_FFFF);
    // multu with an independent addu while the unit runs
    issue(IT_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 0, 32'h302C, 5'd0, 0, 32'h0);
    issue(IT_ADDU, 32'd2, 32'd3, 0, 0, 32'h3030, 5'd8, 0, 32'd5);
    check_busy("multu_run", 1'b1);
    for (int k = 0; k < 4; k++)
      issue(IT_MFHI, 0, 0, 0, 0, 32'h3034, 5'd9, 1, 32'h0);
    issue(IT_MFHI, 0, 0, 0, 0, 32'h3034, 5'd9, 0, 32'h0000_0001);
    issue(IT_MFLO, 0, 0, 0, 0, 32'h3038, 5'd9, 0, 32'hFFFF_FFFE);
  endtask

`ifdef DIV_EN
  task automatic test_div();
    issue(IT_DIVU, 32'd100, 32'd7, 0, 0, 32'h3040, 5'd0, 0, 32'h0);
    issue(IT_ADDU, 32'd1, 32'd1, 0, 0, 32'h3044, 5'd8, 0, 32'd2);
    check_busy("divu_run", 1'b1);
    for (int k = 0; k < 9; k++)
      issue(IT_MFLO, 0, 0, 0, 0, 32'h3048, 5'd9, 1, 32'h0);
    issue(IT_MFLO, 0, 0, 0, 0, 32'h3048, 5'd9, 0, 32'd14);
    issue(IT_MFHI, 0, 0, 0, 0, 32'h304C, 5'd9, 0, 32'd2);
    // signed: -7 / 2 -> q=-3, r=-1
    issue(IT_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 32'h3050, 5'd0, 0, 32'h0);
    for (int k = 0; k < 10; k++)
      issue(IT_MFLO, 0, 0, 0, 0, 32'h3054, 5'd9, 1, 32'h0);
    issue(IT_MFLO, 0, 0, 0, 0, 32'h3054, 5'd9, 0, 32'hFFFF_FFFD);
    issue(IT_MFHI, 0, 0, 0, 0, 32'h3058, 5'd9, 0, 32'hFFFF_FFFF);
    // divide by zero keeps HI/LO
    issue(IT_DIV, 32'd0, 32'd0, 0, 0, 32'h305C, 5'd0, 0, 32'h0);
    for (int k = 0; k < 10; k++)
      issue(IT_MFLO, 0, 0, 0, 0, 32'h3060, 5'd9, 1, 32'h0);
    issue(IT_MFLO, 0, 0, 0, 0, 32'h3060, 5'd9, 0, 32'hFFFF_FFFD);
    issue(IT_MFHI, 0, 0, 0, 0, 32'h3064, 5'd9, 0, 32'hFFFF_FFFF);
  endtask
`else
  task automatic test_no_div();
    issue(IT_MTHI, 32'h1111_1111, 0, 0, 0, 32'h3040, 5'd0, 0, 32'h0);
    issue(IT_MTLO, 32'h2222_2222, 0, 0, 0, 32'h3044, 5'd0, 0, 32'h0);
    issue(IT_DIV, 32'd8, 32'd2, 0, 0, 32'h3048, 5'd0, 0, 32'h0);
    check_busy("div_disabled", 1'b0);
    issue(IT_DIVU, 32'd8, 32'd2, 0, 0, 32'h304C, 5'd0, 0, 32'h0);
    check_busy("divu_disabled", 1'b0);
    issue(IT_MFHI, 0, 0, 0, 0, 32'h3050, 5'd9, 0, 32'h1111_1111);
    issue(IT_MFLO, 0, 0, 0, 0, 32'h3054, 5'd9, 0, 32'h2222_2222);
  endtask
`endif

  task automatic test_reset_mid_op();
    // HI/LO are nonzero here, so a zero read after reset is meaningful
`ifdef DIV_EN
    issue(IT_DIV, 32'd100, 32'd7, 0, 0, 32'h3070, 5'd0, 0, 32'h0);
`else
    issue(IT_MULT, 32'hFFFF_FFFD, 32'd7, 0, 0, 32'h3070, 5'd0, 0, 32'h0);
`endif
    issue(-1, 0, 0, 0, 0, 32'h3074, 5'd0, 0, 32'h0);
    issue(-1, 0, 0, 0, 0, 32'h3078, 5'd0, 0, 32'h0);
    check_busy("pre_reset", 1'b1);
    idle_inputs();
    itype[IT_MFLO] = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_pc = 32'h0000_3000;
    check_reset_state("reset_mid_op");
    issue(IT_MFLO, 0, 0, 0, 0, 32'h3080, 5'd9, 0, 32'h0);
    issue(IT_MFHI, 0, 0, 0, 0, 32'h3084, 5'd9, 0, 32'h0);
  endtask

  initial begin
    idle_inputs();
    reset  = 1'b1;
    exp_pc = 32'h0000_3000;
    @(posedge clk); #1;
    test_reset();
    test_alu();
    test_mult();
`ifdef DIV_EN
    test_div();
`else
    test_no_div();
`endif
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
